pcie_os_gen: RTL and testbench
==============================

Name: pcie_os_gen

Overview:
Parametrised PCIe ordered-set transmitter for the PHY TX path, driven by the LTSSM. Accepts one request describing an OS type and a repeat count. Streams the ordered sets over LANES lanes at SYM_PER_BEAT symbols per lane per beat, using a valid/ready stream. Inserts SKP ordered sets periodically in 8b/10b mode. Supports gen1/2 (K-coded) and gen3 (no K flags) symbol content.

Parameters:
LANES, 4, number of lanes (1..16)
SYM_PER_BEAT, 2, symbols per lane per beat (1, 2 or 4)
SKP_INTERVAL, 8, non-SKP OSes between inserted SKP OSes; 0 disables insertion
BEAT_W, LANES*SYM_PER_BEAT*8, derived data width

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
req_valid_i  in  1  request valid
req_ready_o  out  1  request accepted when valid&ready
req_type_i  in  3  0 TS1, 1 TS2, 2 IDLE, 3 SDS, 4 EIEOS, 5 SKP, 6/7 treated as IDLE
req_count_i  in  8  number of OSes to send; 0 = continuous until stop_i
gen3_i  in  1  gen3 content, no K flags, SKP insertion off
link_num_i  in  8  link number; 8'hF7 means PAD
lane_base_i  in  8  lane number of lane 0; 8'hF7 means PAD on all lanes
n_fts_i  in  8  TS symbol 3
rate_id_i  in  8  TS symbol 4
train_ctl_i  in  8  TS symbol 5
stop_i  in  1  end continuous mode after the current OS
m_data_o  out  BEAT_W  lane l, symbol s at bits [(l*SYM_PER_BEAT+s)*8 +: 8]
m_datak_o  out  LANES*SYM_PER_BEAT  K flag per symbol, same ordering
m_valid_o  out  1  beat valid
m_ready_i  in  1  downstream ready
m_last_o  out  1  last beat of an OS
busy_o  out  1  request in progress

Behaviour:
- Reset: m_valid_o, m_last_o, busy_o = 0; m_data_o, m_datak_o = 0; req_ready_o = 1; SKP counter = 0; state IDLE.
- States:
  - IDLE: req_ready_o = 1. On acceptance, latch all req/config inputs and go to SEND. First beat is valid on the next cycle.
  - SEND: emit the 16-symbol OS over 16/SYM_PER_BEAT beats.
  - SKIP: emit a 4-symbol SKP OS over 4/SYM_PER_BEAT beats.
- Stream handshake:
  - A beat advances only when m_valid_o & m_ready_i are both high.
  - While stalled, m_data_o, m_datak_o and m_last_o hold stable.
  - Back-to-back OSes run with no bubble.
- OS content in gen1/2; symbol index is within the OS:
  - TS1/TS2: 0 COM(K); 1 link or PAD(K); 2 lane_base+l or PAD(K); 3 n_fts; 4 rate_id; 5 train_ctl; 6-15 4A (TS1) or 45 (TS2).
  - IDLE: {COM(K), IDL(K) x3} repeated 4 times.
  - SDS: E1, then 55 x15.
  - EIEOS: COM(K), then EIE(K) x15.
  - SKP: COM(K), SKP 1C(K) x3.
  - lane_base+l wraps mod 256; if the result equals F7 it is still sent as data.
- OS content in gen3:
  - All m_datak_o = 0; byte values otherwise as in gen1/2.
  - IDLE is 66 x16.
  - EIEOS: even symbol = FF, odd symbol = 00.
- Count and termination:
  - count>0: after count completed OSes, return to IDLE and assert req_ready_o the next cycle.
  - count=0: repeat until stop_i has been seen high (sampled at any cycle), then finish the current OS and go to IDLE.
- SKP insertion (gen1/2 only, SKP_INTERVAL>0):
  - The counter increments on the last beat of each non-SKP OS and persists across requests.
  - When it reaches SKP_INTERVAL at an OS boundary, go to SKIP, then clear the counter.
  - An inserted SKP is not counted toward req_count.
  - If the final OS of a burst hits the interval, the SKP is still emitted before IDLE.
  - A requested SKP (type 5) also clears the counter.
- busy_o is high in SEND and SKIP.
- Reset mid-OS immediately applies the reset values; no partial completion.

Test Plan:
- LANES=4, SYM_PER_BEAT=2, TS1, count=2, link=0, lane_base=0, m_ready=1 -> 16 beats. Beat 0 lane2 = {sym1 00, sym0 BC}, K=01. Beats 3-7 carry 4A. m_last on beats 7 and 15. req_ready returns on the cycle after beat 15.
- TS2, link=F7, lane_base=F7 -> symbols 1,2 = F7 with K=1 on every lane; symbols 6-15 = 45.
- IDLE, count=10, SKP_INTERVAL=8 -> after OS 8, SKP OS BC,1C,1C,1C (K=1111), then 2 more IDLE; total 11 m_last.
- gen3_i=1, EIEOS, count=1 -> bytes FF,00 alternating; all K=0; no SKP inserted regardless of counter.
- Continuous SDS, random m_ready stalls, stop_i pulsed mid-OS -> data stable during stalls; current OS completes (E1 then 55); then IDLE.
- rst_ni low in mid-beat with m_valid=1 -> m_valid=0 immediately; after release, req_ready=1 and SKP counter is 0.

Source files
------------

// File: rtl/pcie_os_gen.sv
// PCIe ordered-set transmitter for the PHY TX path, driven by the LTSSM.
// Ports: req_* request in, link/lane/n_fts/rate/train config, m_* beat stream.
module pcie_os_gen #(
  parameter int LANES        = 4,
  parameter int SYM_PER_BEAT = 2,
  parameter int SKP_INTERVAL = 8,
  parameter int BEAT_W       = LANES * SYM_PER_BEAT * 8
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic [2:0]                      req_type_i,
  input  logic [7:0]                      req_count_i,
  input  logic                            gen3_i,
  input  logic [7:0]                      link_num_i,
  input  logic [7:0]                      lane_base_i,
  input  logic [7:0]                      n_fts_i,
  input  logic [7:0]                      rate_id_i,
  input  logic [7:0]                      train_ctl_i,
  input  logic                            stop_i,
  output logic [BEAT_W-1:0]               m_data_o,
  output logic [LANES*SYM_PER_BEAT-1:0]   m_datak_o,
  output logic                            m_valid_o,
  input  logic                            m_ready_i,
  output logic                            m_last_o,
  output logic                            busy_o
);

  localparam logic [3:0] OS_LAST  = 4'(16 / SYM_PER_BEAT - 1);
  localparam logic [3:0] SKP_LAST = 4'(4 / SYM_PER_BEAT - 1);

  localparam logic [7:0] COM = 8'hBC;
  localparam logic [7:0] PAD = 8'hF7;
  localparam logic [7:0] IDL = 8'h7C;
  localparam logic [7:0] EIE = 8'hFC;
  localparam logic [7:0] SKP = 8'h1C;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SEND,
    ST_SKIP
  } state_e;

  typedef enum logic [2:0] {
    OS_TS1  = 3'd0,
    OS_TS2  = 3'd1,
    OS_IDLE = 3'd2,
    OS_SDS  = 3'd3,
    OS_EIE  = 3'd4,
    OS_SKP  = 3'd5
  } os_e;

  state_e      state_q, state_d;
  os_e         type_q, type_d;
  logic [3:0]  beat_q, beat_d;
  logic [7:0]  rem_q, rem_d;
  logic        cont_q, cont_d;
  logic        stop_q, stop_d;
  logic        fin_q, fin_d;
  logic        gen3_q, gen3_d;
  logic [7:0]  link_q, link_d;
  logic [7:0]  lane_q, lane_d;
  logic [7:0]  nfts_q, nfts_d;
  logic [7:0]  rate_q, rate_d;
  logic [7:0]  tctl_q, tctl_d;
  logic [7:0]  skp_q, skp_d;

  os_e         cur_type;
  logic [3:0]  last_beat;
  logic        fire;
  logic [7:0]  skp_inc;
  logic        skp_hit;
  logic        fin;
  logic [8:0]  sym;
  logic [BEAT_W-1:0]             data;
  logic [LANES*SYM_PER_BEAT-1:0] datak;

  // Returns {K, byte} for symbol i of an OS on one lane.
  function automatic logic [8:0] os_sym(
    input os_e        t,
    input logic       g3,
    input logic [3:0] i,
    input logic [7:0] ln,
    input logic       pad_ln,
    input logic [7:0] lk,
    input logic [7:0] nf,
    input logic [7:0] rt,
    input logic [7:0] tc
  );
    logic       k;
    logic [7:0] b;
    k = 1'b0;
    b = 8'h00;
    case (t)
      OS_TS1, OS_TS2: begin
        unique case (i)
          4'd0: begin b = COM; k = 1'b1; end
          4'd1: begin b = lk; k = (lk == PAD); end
          4'd2: begin
            b = pad_ln ? PAD : ln;
            k = pad_ln;
          end
          4'd3: b = nf;
          4'd4: b = rt;
          4'd5: b = tc;
          default: b = (t == OS_TS1) ? 8'h4A : 8'h45;
        endcase
      end
      OS_SDS: b = (i == 4'd0) ? 8'hE1 : 8'h55;
      OS_EIE: begin
        if (g3) begin
          b = i[0] ? 8'h00 : 8'hFF;
        end else begin
          b = (i == 4'd0) ? COM : EIE;
          k = 1'b1;
        end
      end
      OS_SKP: begin
        b = (i == 4'd0) ? COM : SKP;
        k = 1'b1;
      end
      default: begin
        if (g3) begin
          b = 8'h66;
        end else begin
          b = (i[1:0] == 2'd0) ? COM : IDL;
          k = 1'b1;
        end
      end
    endcase
    if (g3) k = 1'b0;
    return {k, b};
  endfunction

  assign cur_type  = (state_q == ST_SKIP) ? OS_SKP : type_q;
  assign last_beat = (cur_type == OS_SKP) ? SKP_LAST : OS_LAST;

  assign m_valid_o   = (state_q != ST_IDLE);
  assign req_ready_o = (state_q == ST_IDLE);
  assign busy_o      = m_valid_o;
  assign m_last_o    = m_valid_o && (beat_q == last_beat);
  assign m_data_o    = data;
  assign m_datak_o   = datak;
  assign fire        = m_valid_o & m_ready_i;

  // Saturate so a long gen3 run cannot wrap the counter.
  assign skp_inc = (skp_q == 8'hFF) ? skp_q : skp_q + 8'd1;
  assign skp_hit = (SKP_INTERVAL > 0) && !gen3_q &&
                   (type_q != OS_SKP) &&
                   (int'(skp_inc) >= SKP_INTERVAL);

  always_comb begin
    data  = '0;
    datak = '0;
    sym   = '0;
    if (state_q != ST_IDLE) begin
      for (int l = 0; l < LANES; l++) begin
        for (int s = 0; s < SYM_PER_BEAT; s++) begin
          sym = os_sym(cur_type, gen3_q,
                       4'(int'(beat_q) * SYM_PER_BEAT + s),
                       lane_q + 8'(l), (lane_q == PAD),
                       link_q, nfts_q, rate_q, tctl_q);
          data[(l*SYM_PER_BEAT+s)*8 +: 8] = sym[7:0];
          datak[l*SYM_PER_BEAT+s]         = sym[8];
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    beat_d  = beat_q;
    rem_d   = rem_q;
    cont_d  = cont_q;
    stop_d  = stop_q;
    fin_d   = fin_q;
    gen3_d  = gen3_q;
    link_d  = link_q;
    lane_d  = lane_q;
    nfts_d  = nfts_q;
    rate_d  = rate_q;
    tctl_d  = tctl_q;
    skp_d   = skp_q;
    fin     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (req_valid_i) begin
          state_d = ST_SEND;
          beat_d  = 4'd0;
          rem_d   = req_count_i;
          cont_d  = (req_count_i == 8'd0);
          stop_d  = 1'b0;
          fin_d   = 1'b0;
          gen3_d  = gen3_i;
          link_d  = link_num_i;
          lane_d  = lane_base_i;
          nfts_d  = n_fts_i;
          rate_d  = rate_id_i;
          tctl_d  = train_ctl_i;
          unique case (req_type_i)
            3'd0:    type_d = OS_TS1;
            3'd1:    type_d = OS_TS2;
            3'd3:    type_d = OS_SDS;
            3'd4:    type_d = OS_EIE;
            3'd5:    type_d = OS_SKP;
            default: type_d = OS_IDLE;
          endcase
        end
      end
      ST_SEND: begin
        if (stop_i) stop_d = 1'b1;
        if (fire) begin
          if (beat_q != last_beat) begin
            beat_d = beat_q + 4'd1;
          end else begin
            beat_d = 4'd0;
            fin = cont_q ? (stop_q | stop_i) : (rem_q == 8'd1);
            if (!cont_q) rem_d = rem_q - 8'd1;
            skp_d = (type_q == OS_SKP) ? 8'd0 : skp_inc;
            if (skp_hit) begin
              state_d = ST_SKIP;
              fin_d   = fin;
            end else if (fin) begin
              state_d = ST_IDLE;
            end
          end
        end
      end
      ST_SKIP: begin
        if (stop_i) stop_d = 1'b1;
        if (fire) begin
          if (beat_q != last_beat) begin
            beat_d = beat_q + 4'd1;
          end else begin
            beat_d = 4'd0;
            skp_d  = 8'd0;
            fin = fin_q | (cont_q & (stop_q | stop_i));
            state_d = fin ? ST_IDLE : ST_SEND;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      type_q  <= OS_TS1;
      beat_q  <= 4'd0;
      rem_q   <= 8'd0;
      cont_q  <= 1'b0;
      stop_q  <= 1'b0;
      fin_q   <= 1'b0;
      gen3_q  <= 1'b0;
      link_q  <= 8'd0;
      lane_q  <= 8'd0;
      nfts_q  <= 8'd0;
      rate_q  <= 8'd0;
      tctl_q  <= 8'd0;
      skp_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      beat_q  <= beat_d;
      rem_q   <= rem_d;
      cont_q  <= cont_d;
      stop_q  <= stop_d;
      fin_q   <= fin_d;
      gen3_q  <= gen3_d;
      link_q  <= link_d;
      lane_q  <= lane_d;
      nfts_q  <= nfts_d;
      rate_q  <= rate_d;
      tctl_q  <= tctl_d;
      skp_q   <= skp_d;
    end
  end

endmodule

// File: tb/tb_pcie_os_gen.sv
// Directed bench for pcie_os_gen (LANES=4, SYM_PER_BEAT=2, SKP_INTERVAL=8).
// Beats are captured on negedge and compared to hand-computed words.
module tb_pcie_os_gen;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_ready_o;
  logic [2:0]  req_type_i = '0;
  logic [7:0]  req_count_i = '0;
  logic        gen3_i = 1'b0;
  logic [7:0]  link_num_i = '0;
  logic [7:0]  lane_base_i = '0;
  logic [7:0]  n_fts_i = 8'h10;
  logic [7:0]  rate_id_i = 8'h02;
  logic [7:0]  train_ctl_i = 8'h00;
  logic        stop_i = 1'b0;
  logic [63:0] m_data_o;
  logic [7:0]  m_datak_o;
  logic        m_valid_o;
  logic        m_ready_i = 1'b1;
  logic        m_last_o;
  logic        busy_o;

  pcie_os_gen #(
    .LANES(4),
    .SYM_PER_BEAT(2),
    .SKP_INTERVAL(8)
  ) dut (
    .clk_i(clk_i),
    .rst_ni(rst_ni),
    .req_valid_i(req_valid_i),
    .req_ready_o(req_ready_o),
    .req_type_i(req_type_i),
    .req_count_i(req_count_i),
    .gen3_i(gen3_i),
    .link_num_i(link_num_i),
    .lane_base_i(lane_base_i),
    .n_fts_i(n_fts_i),
    .rate_id_i(rate_id_i),
    .train_ctl_i(train_ctl_i),
    .stop_i(stop_i),
    .m_data_o(m_data_o),
    .m_datak_o(m_datak_o),
    .m_valid_o(m_valid_o),
    .m_ready_i(m_ready_i),
    .m_last_o(m_last_o),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad = 0;

  logic [63:0] bd [0:127];
  logic [7:0]  bk [0:127];
  logic        bl [0:127];
  int nb, nl, gap;
  bit stall_en = 1'b0;
  int stop_beat = -1;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  task automatic send_req(input logic [2:0] t,
                          input logic [7:0] c,
                          input logic       g3,
                          input logic [7:0] lk,
                          input logic [7:0] lb);
    @(negedge clk_i);
    chk("req_ready", {63'd0, req_ready_o}, 64'd1);
    req_type_i  = t;
    req_count_i = c;
    gen3_i      = g3;
    link_num_i  = lk;
    lane_base_i = lb;
    req_valid_i = 1'b1;
    @(posedge clk_i);
    #1;
    req_valid_i = 1'b0;
  endtask

  task automatic collect(input int budget);
    int cyc;
    int last_c;
    bit held;
    logic [63:0] hd;
    logic [7:0]  hk;
    cyc = 0;
    last_c = 0;
    held = 1'b0;
    hd = '0;
    hk = '0;
    nb = 0;
    nl = 0;
    gap = -1;
    forever begin
      @(negedge clk_i);
      cyc++;
      if (cyc == 1) chk("first_valid", {63'd0, m_valid_o}, 64'd1);
      if (held) begin
        chk("stall_data", m_data_o, hd);
        chk("stall_k", {56'd0, m_datak_o}, {56'd0, hk});
      end
      held = m_valid_o && !m_ready_i;
      hd = m_data_o;
      hk = m_datak_o;
      if (m_valid_o && m_ready_i && nb < 128) begin
        bd[nb] = m_data_o;
        bk[nb] = m_datak_o;
        bl[nb] = m_last_o;
        nb++;
        if (m_last_o) nl++;
        last_c = cyc;
      end
      if (req_ready_o && !m_valid_o && nb > 0) begin
        gap = cyc - last_c;
        break;
      end
      if (cyc >= budget) begin
        chk("timeout", 64'd0, 64'd1);
        break;
      end
      @(posedge clk_i);
      #1;
      stop_i = 1'b0;
      if (nb == stop_beat) begin
        stop_i = 1'b1;
        stop_beat = -1;
      end
      if (stall_en) m_ready_i = ($urandom_range(0, 3) != 0);
    end
    stop_i = 1'b0;
    m_ready_i = 1'b1;
  endtask

  initial begin
    #1;
    chk("rst_valid", {63'd0, m_valid_o}, 64'd0);
    chk("rst_ready", {63'd0, req_ready_o}, 64'd1);
    chk("rst_busy", {63'd0, busy_o}, 64'd0);
    chk("rst_data", m_data_o, 64'd0);
    chk("rst_last", {63'd0, m_last_o}, 64'd0);
    do_reset();

    // TS1 x2, link 0, lane_base 0
    send_req(3'd0, 8'd2, 1'b0, 8'h00, 8'h00);
    collect(300);
    chk("ts1_beats", 64'(nb), 64'd16);
    chk("ts1_lasts", 64'(nl), 64'd2);
    chk("ts1_gap", 64'(gap), 64'd1);
    chk("ts1_b0", bd[0], 64'h00BC_00BC_00BC_00BC);
    chk("ts1_k0", {56'd0, bk[0]}, 64'h55);
    chk("ts1_b1", bd[1], 64'h1003_1002_1001_1000);
    chk("ts1_b2", bd[2], 64'h0002_0002_0002_0002);
    chk("ts1_b3", bd[3], 64'h4A4A_4A4A_4A4A_4A4A);
    chk("ts1_b7", bd[7], 64'h4A4A_4A4A_4A4A_4A4A);
    chk("ts1_k5", {56'd0, bk[5]}, 64'h00);
    chk("ts1_l6", {63'd0, bl[6]}, 64'd0);
    chk("ts1_l7", {63'd0, bl[7]}, 64'd1);
    chk("ts1_l15", {63'd0, bl[15]}, 64'd1);
    chk("ts1_b8", bd[8], 64'h00BC_00BC_00BC_00BC);

    // TS2 with PAD link and lane
    send_req(3'd1, 8'd1, 1'b0, 8'hF7, 8'hF7);
    collect(300);
    chk("ts2_beats", 64'(nb), 64'd8);
    chk("ts2_b0", bd[0], 64'hF7BC_F7BC_F7BC_F7BC);
    chk("ts2_k0", {56'd0, bk[0]}, 64'hFF);
    chk("ts2_b1", bd[1], 64'h10F7_10F7_10F7_10F7);
    chk("ts2_k1", {56'd0, bk[1]}, 64'h55);
    chk("ts2_b3", bd[3], 64'h4545_4545_4545_4545);
    chk("ts2_b7", bd[7], 64'h4545_4545_4545_4545);

    // lane_base+l reaching F7 is plain data
    send_req(3'd0, 8'd1, 1'b0, 8'h03, 8'hF5);
    collect(300);
    chk("lane_b1", bd[1], 64'h10F8_10F7_10F6_10F5);
    chk("lane_k1", {56'd0, bk[1]}, 64'h00);
    chk("link_b0", bd[0], 64'h03BC_03BC_03BC_03BC);

    // IDLE x10 with SKP after the 8th
    do_reset();
    send_req(3'd2, 8'd10, 1'b0, 8'h00, 8'h00);
    collect(300);
    chk("idl_beats", 64'(nb), 64'd82);
    chk("idl_lasts", 64'(nl), 64'd11);
    chk("idl_b0", bd[0], 64'h7CBC_7CBC_7CBC_7CBC);
    chk("idl_k0", {56'd0, bk[0]}, 64'hFF);
    chk("idl_b1", bd[1], 64'h7C7C_7C7C_7C7C_7C7C);
    chk("idl_l63", {63'd0, bl[63]}, 64'd1);
    chk("skp_b64", bd[64], 64'h1CBC_1CBC_1CBC_1CBC);
    chk("skp_k64", {56'd0, bk[64]}, 64'hFF);
    chk("skp_b65", bd[65], 64'h1C1C_1C1C_1C1C_1C1C);
    chk("skp_l65", {63'd0, bl[65]}, 64'd1);
    chk("idl_b66", bd[66], 64'h7CBC_7CBC_7CBC_7CBC);

    // gen3 EIEOS after counter is at 7: no SKP
    do_reset();
    send_req(3'd2, 8'd7, 1'b0, 8'h00, 8'h00);
    collect(300);
    chk("pre_beats", 64'(nb), 64'd56);
    send_req(3'd4, 8'd1, 1'b1, 8'h00, 8'h00);
    collect(300);
    chk("g3_beats", 64'(nb), 64'd8);
    chk("g3_lasts", 64'(nl), 64'd1);
    chk("g3_b0", bd[0], 64'h00FF_00FF_00FF_00FF);
    chk("g3_b5", bd[5], 64'h00FF_00FF_00FF_00FF);
    chk("g3_k0", {56'd0, bk[0]}, 64'h00);
    chk("g3_k7", {56'd0, bk[7]}, 64'h00);

    // reset in the middle of a continuous TS1 run
    send_req(3'd0, 8'd0, 1'b0, 8'h00, 8'h00);
    repeat (3) @(posedge clk_i);
    #2;
    chk("pre_rst_valid", {63'd0, m_valid_o}, 64'd1);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", {63'd0, m_valid_o}, 64'd0);
    chk("mid_rst_data", m_data_o, 64'd0);
    chk("mid_rst_busy", {63'd0, busy_o}, 64'd0);
    chk("mid_rst_ready", {63'd0, req_ready_o}, 64'd1);
    @(negedge clk_i);
    rst_ni = 1'b1;
    send_req(3'd2, 8'd8, 1'b0, 8'h00, 8'h00);
    collect(300);
    chk("rst_skp_beats", 64'(nb), 64'd66);
    chk("rst_skp_lasts", 64'(nl), 64'd9);
    chk("rst_skp_b2", bd[2], 64'h7CBC_7CBC_7CBC_7CBC);
    chk("rst_skp_b64", bd[64], 64'h1CBC_1CBC_1CBC_1CBC);

    // continuous SDS with stalls, stop pulsed mid second OS
    do_reset();
    stall_en = 1'b1;
    stop_beat = 10;
    send_req(3'd3, 8'd0, 1'b0, 8'h00, 8'h00);
    collect(400);
    stall_en = 1'b0;
    chk("sds_beats", 64'(nb), 64'd16);
    chk("sds_lasts", 64'(nl), 64'd2);
    chk("sds_b0", bd[0], 64'h55E1_55E1_55E1_55E1);
    chk("sds_k0", {56'd0, bk[0]}, 64'h00);
    chk("sds_b1", bd[1], 64'h5555_5555_5555_5555);
    chk("sds_b8", bd[8], 64'h55E1_55E1_55E1_55E1);
    chk("sds_b15", bd[15], 64'h5555_5555_5555_5555);
    chk("sds_busy", {63'd0, busy_o}, 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
